// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, privileged-return drain/redirect
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_br_taken,
  input  logic [1:0]  ex_priv_ret,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        redirect_valid,
  output logic [1:0]  redirect_sel,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  // Drain counter is wide enough to hold DRAIN_CYCLES; at least one bit.
  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] DRAIN_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] drain_q, drain_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic [15:0]   flush_cnt_q, flush_cnt_d;

  logic lu;
  logic stall_inc;
  logic flush_inc;

  // Load-use hazard: EX load writes a register that the ID instruction reads; x0 never hazards.
  always_comb begin
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state and hazard outputs; RUN outputs follow current inputs with no latency.
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    sel_d          = sel_q;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel   = 2'b00;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_priv_ret != 2'b00) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          sel_d       = ex_priv_ret;
          drain_d     = DRAIN_LOAD;
          state_d     = (DRAIN_CYCLES == 0) ? ST_REDIRECT : ST_DRAIN;
        end else if (ex_br_taken) begin
          // A taken branch kills the ID instruction, so any load-use stall is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (lu) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Keep the front end empty while the return settles; new events are ignored.
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        drain_d     = drain_q - DRAIN_ONE;
        if (drain_q <= DRAIN_ONE) begin
          state_d = ST_REDIRECT;
        end
      end

      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_sel   = sel_q;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        drain_d        = '0;
        sel_d          = 2'b00;
        state_d        = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
        drain_d = '0;
        sel_d   = 2'b00;
      end
    endcase

    // Reset silences every output regardless of inputs.
    if (rst) begin
      pc_stall       = 1'b0;
      if_id_stall    = 1'b0;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      redirect_valid = 1'b0;
      redirect_sel   = 2'b00;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
    end
  end

  // Saturating performance counters: stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // State, drain counter, latched return code and counters; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      sel_q       <= 2'b00;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      sel_q       <= sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Counter outputs also read zero while reset is held.
  always_comb begin
    stall_cnt = rst ? 16'd0 : stall_cnt_q;
    flush_cnt = rst ? 16'd0 : flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
  logic [1:0]  ex_priv_ret;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, redirect_valid;
  logic [1:0]  redirect_sel;
  logic [15:0] stall_cnt, flush_cnt;

  logic        z_pc_stall, z_if_id_stall, z_if_id_flush, z_id_ex_flush, z_redirect_valid;
  logic [1:0]  z_redirect_sel;
  logic [15:0] z_stall_cnt, z_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_priv_ret(ex_priv_ret),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.DRAIN_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_priv_ret(ex_priv_ret),
    .pc_stall(z_pc_stall), .if_id_stall(z_if_id_stall), .if_id_flush(z_if_id_flush), .id_ex_flush(z_id_ex_flush),
    .redirect_valid(z_redirect_valid), .redirect_sel(z_redirect_sel),
    .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, redirect_valid}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_STALL = 5'b11010;
  localparam logic [4:0] O_BR    = 5'b00110;
  localparam logic [4:0] O_DRAIN = 5'b10110;
  localparam logic [4:0] O_REDIR = 5'b00111;

  function automatic logic [4:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_flush, redirect_valid};
  endfunction

  function automatic logic [4:0] z_outs();
    return {z_pc_stall, z_if_id_stall, z_if_id_flush, z_id_ex_flush, z_redirect_valid};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_br_taken = 1'b0; ex_priv_ret = 2'b00;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    set_lu(); ex_br_taken = 1'b1; ex_priv_ret = 2'b10;
    #1;
    check("rst_outs_pre", {11'd0, outs()}, {11'd0, O_IDLE});
    check("rst_sel_pre", {14'd0, redirect_sel}, 16'd0);
    tick();
    check("rst_outs", {11'd0, outs()}, {11'd0, O_IDLE});
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_flush_cnt", flush_cnt, 16'd0);
    tick();
    rst = 1'b0; idle(); #1;
    check("run_idle", {11'd0, outs()}, {11'd0, O_IDLE});
    check("idle_cnt", stall_cnt, 16'd0);

    // Load-use through rs2.
    set_lu(); #1;
    check("lu_rs2_outs", {11'd0, outs()}, {11'd0, O_STALL});
    tick();
    check("lu_rs2_cnt", stall_cnt, 16'd1);
    // Load-use through rs1.
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; #1;
    check("lu_rs1_outs", {11'd0, outs()}, {11'd0, O_STALL});
    tick();
    check("lu_rs1_cnt", stall_cnt, 16'd2);
    // Matching index but operand unused.
    idle(); set_lu(); id_use_rs2 = 1'b0; #1;
    check("lu_unused", {11'd0, outs()}, {11'd0, O_IDLE});
    // Not a load.
    idle(); set_lu(); ex_mem_read = 1'b0; #1;
    check("lu_noload", {11'd0, outs()}, {11'd0, O_IDLE});
    // x0 destination never hazards.
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
    check("lu_x0_outs", {11'd0, outs()}, {11'd0, O_IDLE});
    tick();
    check("lu_x0_cnt", stall_cnt, 16'd2);

    // Taken branch overrides load-use.
    idle(); set_lu(); ex_br_taken = 1'b1; #1;
    check("br_lu_outs", {11'd0, outs()}, {11'd0, O_BR});
    tick();
    check("br_flush_cnt", flush_cnt, 16'd1);
    check("br_stall_cnt", stall_cnt, 16'd2);

    // Privileged return, code 3.
    idle(); ex_priv_ret = 2'b11; #1;
    check("pr_c0_outs", {11'd0, outs()}, {11'd0, O_DRAIN});
    check("pr_c0_sel", {14'd0, redirect_sel}, 16'd0);
    check("z_c0_outs", {11'd0, z_outs()}, {11'd0, O_DRAIN});
    tick();
    idle(); set_lu(); ex_br_taken = 1'b1; ex_priv_ret = 2'b01; #1;
    check("pr_c1_outs", {11'd0, outs()}, {11'd0, O_DRAIN});
    check("z_c1_outs", {11'd0, z_outs()}, {11'd0, O_REDIR});
    check("z_c1_sel", {14'd0, z_redirect_sel}, 16'd3);
    tick();
    idle(); #1;
    check("pr_c2_outs", {11'd0, outs()}, {11'd0, O_DRAIN});
    check("z_c2_outs", {11'd0, z_outs()}, {11'd0, O_IDLE});
    tick();
    check("pr_c3_outs", {11'd0, outs()}, {11'd0, O_REDIR});
    check("pr_c3_sel", {14'd0, redirect_sel}, 16'd3);
    tick();
    check("pr_c4_outs", {11'd0, outs()}, {11'd0, O_IDLE});
    check("pr_c4_sel", {14'd0, redirect_sel}, 16'd0);
    check("pr_flush_cnt", flush_cnt, 16'd1);
    check("pr_stall_cnt", stall_cnt, 16'd2);

    // Privileged return, code 1: selector follows the latched code.
    ex_priv_ret = 2'b01; tick(); idle(); tick(); tick();
    check("pr1_sel", {14'd0, redirect_sel}, 16'd1);
    check("pr1_outs", {11'd0, outs()}, {11'd0, O_REDIR});
    tick();

    // Reset during DRAIN cycle 1 kills the pending redirect.
    ex_priv_ret = 2'b10; tick(); idle();
    check("rd_c1_outs", {11'd0, outs()}, {11'd0, O_DRAIN});
    rst = 1'b1; #1;
    check("rd_rst_outs", {11'd0, outs()}, {11'd0, O_IDLE});
    tick();
    rst = 1'b0; #1;
    check("rd_after_outs", {11'd0, outs()}, {11'd0, O_IDLE});
    check("rd_after_cnt", flush_cnt, 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_no_redir", {15'd0, redirect_valid}, 16'd0);
    end
    set_lu(); #1;
    check("rd_run_lu", {11'd0, outs()}, {11'd0, O_STALL});
    tick();
    check("rd_run_cnt", stall_cnt, 16'd1);

    // Saturation: counter continues from 1.
    for (int i = 0; i < 65533; i++) tick();
    check("sat_pre", stall_cnt, 16'hFFFE);
    tick();
    check("sat_hit", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) tick();
    check("sat_hold", stall_cnt, 16'hFFFF);
    check("sat_outs", {11'd0, outs()}, {11'd0, O_STALL});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
